// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: small byte FIFO feeding a frame serialiser.
// Frames are 5-8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int OVS        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clk16,
  input  logic [4:0]                    cfg,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx_sn,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(OVS);
  localparam logic [AW-1:0] P1   = AW'(1);
  localparam logic [CW-1:0] C1   = CW'(1);
  localparam logic [CW-1:0] CMAX = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] T1   = TW'(1);
  localparam logic [TW-1:0] TMAX = TW'(OVS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [4:0]    fcfg_q, fcfg_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;

  logic          push;
  logic          pop;
  logic          tick_end;
  logic [7:0]    head;
  logic [7:0]    mask;
  logic [2:0]    last_bit;

  assign wr_ready   = (count_q < CMAX);
  assign push       = wr_valid && wr_ready;
  assign pop        = (state_q == IDLE) && (count_q != '0);
  assign tick_end   = clk16 && (tcnt_q == TMAX);
  assign head       = mem_q[rd_ptr_q];
  assign mask       = 8'hFF >> (2'd3 - cfg[1:0]);
  assign last_bit   = 3'd4 + {1'b0, fcfg_q[1:0]};

  assign tx_sn      = tx_q;
  assign tx_busy    = (state_q != IDLE);
  assign tx_done    = done_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (wr_valid & ~wr_ready);
    if (push) wr_ptr_d = wr_ptr_q + P1;
    if (pop)  rd_ptr_d = rd_ptr_q + P1;
    if (push && !pop)      count_d = count_q + C1;
    else if (!push && pop) count_d = count_q - C1;
  end

  // Frame FSM next state; line level is derived from the next state
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    fcfg_d   = fcfg_q;
    par_d    = par_q;
    done_d   = 1'b0;
    tx_d     = 1'b1;
    if (clk16 && state_q != IDLE) begin
      tcnt_d = tick_end ? '0 : tcnt_q + T1;
    end
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d  = head;
          fcfg_d   = cfg;
          par_d    = ^(head & mask);
          tcnt_d   = '0;
          bitcnt_d = '0;
          state_d  = START;
        end
      end
      START: begin
        if (tick_end) state_d = DATA;
      end
      DATA: begin
        if (tick_end) begin
          shift_d  = {1'b0, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == last_bit) begin
            bitcnt_d = '0;
            state_d  = fcfg_q[3] ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick_end) state_d = STOP;
      end
      STOP: begin
        if (tick_end) begin
          if (fcfg_q[4] && bitcnt_q == 3'd0) begin
            bitcnt_d = 3'd1;
          end else begin
            bitcnt_d = '0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = fcfg_d[2] ? par_d : ~par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // State registers; reset drives the line idle at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      tcnt_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      fcfg_q   <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      fcfg_q   <= fcfg_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: table vectors, corner sequences and
// randomized traffic against a frame-level reference model.
module tb_uart_tx_fifo;

  localparam int D   = 4;
  localparam int OVS = 16;

  logic       clk, rst_n, clk16;
  logic [4:0] cfg;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic       tx_sn, tx_busy, tx_done, overflow;
  logic [2:0] fifo_count;

  uart_tx_fifo #(.FIFO_DEPTH(D), .OVS(OVS)) dut (
    .clk(clk), .rst_n(rst_n), .clk16(clk16), .cfg(cfg),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .tx_sn(tx_sn), .tx_busy(tx_busy), .tx_done(tx_done),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  typedef struct packed {
    logic [4:0] cfg;
    logic [7:0] data;
  } fr_t;

  typedef struct {
    logic [4:0]  cfg;
    logic [7:0]  data;
    int          ticks;
    logic [15:0] bits;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int tmode = 0;

  fr_t  q[$];
  logic exp_lv[16];
  int   total, tick_idx;
  bit   in_frame, done_pending, meas_active, exp_ovf;
  bit   last_done_valid, pend_at_done;
  int   cyc, meas_ticks, start_cyc, last_done_cyc;
  int   done_cnt, accepted, refused, gap_checks;
  int   last_ticks, last_clks;
  logic [15:0] cap, last_cap;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // expected line level per bit period, straight from the frame format
  function automatic void build(input fr_t f);
    int   n, k;
    logic par;
    n = 5 + int'(f.cfg[1:0]);
    par = 1'b0;
    exp_lv[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_lv[1+i] = f.data[i];
      par ^= f.data[i];
    end
    k = 1 + n;
    if (f.cfg[3]) begin
      exp_lv[k] = f.cfg[2] ? par : ~par;
      k++;
    end
    exp_lv[k] = 1'b1;
    k++;
    if (f.cfg[4]) begin
      exp_lv[k] = 1'b1;
      k++;
    end
    total = k * OVS;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // tick enable: every clk, every 3rd clk, or random
  initial begin
    int div;
    div = 0;
    clk16 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (tmode)
        0: clk16 = 1'b1;
        1: begin
          div = (div == 2) ? 0 : div + 1;
          clk16 = (div == 0);
        end
        default: clk16 = 1'($urandom % 2);
      endcase
    end
  end

  // monitor and reference model, sampled mid-cycle
  initial begin
    fr_t nf;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        q.delete();
        in_frame = 0;
        done_pending = 0;
        meas_active = 0;
        exp_ovf = 0;
        last_done_valid = 0;
      end else begin
        check("tx_done", tx_done, done_pending);
        if (tx_done && meas_active) begin
          last_ticks = meas_ticks;
          last_cap = cap;
          last_clks = cyc - start_cyc;
          meas_active = 0;
          done_cnt++;
          last_done_cyc = cyc;
          last_done_valid = 1;
          pend_at_done = (q.size() > 0);
        end
        done_pending = 0;
        if (!in_frame && tx_sn == 1'b0) begin
          if (q.size() == 0) begin
            check("spurious_start", tx_sn, 1'b1);
          end else begin
            build(q.pop_front());
            in_frame = 1;
            tick_idx = 0;
            meas_active = 1;
            meas_ticks = 0;
            cap = '0;
            start_cyc = cyc;
            if (last_done_valid && pend_at_done) begin
              gap_checks++;
              check("gap", cyc - last_done_cyc, 1);
            end
            last_done_valid = 0;
          end
        end
        check("tx_busy", tx_busy, in_frame);
        if (meas_active && clk16) begin
          if (meas_ticks % OVS == OVS / 2 && meas_ticks / OVS < 16)
            cap[meas_ticks/OVS] = tx_sn;
          meas_ticks++;
        end
        if (in_frame && clk16) begin
          check("line", tx_sn, exp_lv[tick_idx/OVS]);
          tick_idx++;
          if (tick_idx == total) begin
            in_frame = 0;
            done_pending = 1;
          end
        end
        check("fifo_count", fifo_count, q.size());
        check("wr_ready", wr_ready, q.size() < D);
        check("overflow", overflow, exp_ovf);
        if (wr_valid) begin
          if (q.size() < D) begin
            nf.cfg = cfg;
            nf.data = wr_data;
            q.push_back(nf);
            accepted++;
          end else begin
            exp_ovf = 1;
            refused++;
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    @(posedge clk);
    #1;
    wr_valid = 1'b1;
    wr_data = b;
  endtask

  task automatic idle_wr();
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int bound);
    int t;
    t = 0;
    while (done_cnt == d0 && t < bound) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("done_timeout", done_cnt != d0, 1'b1);
  endtask

  task automatic wait_start(input int bound);
    int t;
    t = 0;
    while (!in_frame && t < bound) begin
      @(posedge clk);
      t++;
    end
    check("start_timeout", in_frame, 1'b1);
  endtask

  task automatic wait_idle(input int bound);
    int t;
    t = 0;
    while (!(q.size() == 0 && !in_frame && !done_pending && !meas_active)
           && t < bound) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("idle_timeout", t < bound, 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[6];
    int d0, a0, r0, g0;
    int k, lo;

    tv[0] = '{5'b00011, 8'h55, 160, 16'h02AA};
    tv[1] = '{5'b01110, 8'h83, 160, 16'h0206};
    tv[2] = '{5'b11000, 8'hFF, 144, 16'h01BE};
    tv[3] = '{5'b01101, 8'h3C, 144, 16'h0178};
    tv[4] = '{5'b11011, 8'hA1, 192, 16'h0D42};
    tv[5] = '{5'b00000, 8'hE2, 112, 16'h0044};

    wr_valid = 1'b0;
    wr_data = 8'h00;
    cfg = 5'b00011;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_sn", tx_sn, 1'b1);
    check("rst_count", fifo_count, 0);
    check("rst_ready", wr_ready, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      cfg = tv[i].cfg;
      d0 = done_cnt;
      push(tv[i].data);
      idle_wr();
      wait_done(d0, 1000);
      check("vec_ticks", last_ticks, tv[i].ticks);
      check("vec_bits", last_cap, tv[i].bits);
      check("vec_clks", last_clks, tv[i].ticks);
    end

    cfg = 5'b00011;
    a0 = accepted;
    r0 = refused;
    g0 = gap_checks;
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
    idle_wr();
    check("burst_acc", accepted - a0, 5);
    check("burst_ref", refused - r0, 1);
    check("burst_ovf", overflow, 1'b1);
    wait_idle(6000);
    check("burst_frames", done_cnt - d0, 5);
    check("burst_gaps", gap_checks - g0, 4);

    push(8'h00);
    idle_wr();
    wait_start(20);
    repeat (40) @(posedge clk);
    push(8'h11);
    idle_wr();
    check("pre_rst_low", tx_sn, 1'b0);
    check("pre_rst_cnt", fifo_count, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx_sn, 1'b1);
    check("mid_rst_cnt", fifo_count, 0);
    check("mid_rst_busy", tx_busy, 1'b0);
    check("mid_rst_ovf", overflow, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    d0 = done_cnt;
    push(8'h5A);
    idle_wr();
    wait_done(d0, 1000);
    check("post_rst_ticks", last_ticks, 160);
    check("post_rst_bits", last_cap, 16'h02B4);

    tmode = 1;
    cfg = 5'b01110;
    d0 = done_cnt;
    push(8'h96);
    idle_wr();
    wait_start(50);
    repeat (10) @(posedge clk);
    #1 cfg = 5'b11000;
    wait_done(d0, 2000);
    check("div3_ticks", last_ticks, 160);
    check("div3_bits", last_cap, 16'h032C);
    lo = 3 * 160 - 2;
    check("div3_clks", last_clks >= lo && last_clks <= 3 * 160, 1'b1);

    for (int b = 0; b < 12; b++) begin
      tmode = ($urandom % 2) ? 0 : 2;
      cfg = 5'($urandom);
      k = 1 + $urandom % 5;
      for (int j = 0; j < k; j++) begin
        repeat ($urandom % 3) idle_wr();
        push(8'($urandom));
      end
      idle_wr();
      wait_idle(8000);
    end
    tmode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
